aes_round_engine: RTL and testbench
===================================

Name: aes_round_engine

Overview:
- Iterative AES encryption datapath that sits directly downstream of the key-schedule block.
- Consumes the full concatenated round-key bus once the schedule's finish flag is high, then encrypts one 128-bit block at one round per clock.
- Supports AES-128/192/256, selected by parameter to match the key-schedule instance.
- The ciphertext feeds the mode/output stage.

Parameters:
size, 128, key length in bits (128, 192 or 256); nr = size/32+6 rounds (derived localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
kall  input  128*(size/32+7)  all round keys, round 0 in the MSBs: rk[i] = kall[128*(nr+1)-1-128*i -: 128]
key_ready  input  1  key schedule complete (driven from the schedule's finish)
start  input  1  request to encrypt plaintext; sampled on clk
plaintext  input  128  input block, byte 0 = bits [127:120]
busy  output  1  high while a block is in flight
ciphertext  output  128  result, byte 0 = bits [127:120]
done  output  1  one-cycle pulse, ciphertext valid

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; busy=0; done=0; ciphertext=0; state register=0; round counter=0. Reset asserted mid-block aborts the block with no done.
- States: IDLE, ROUND.
- IDLE:
  - start=1 and key_ready=1 at an edge accept the block: state reg <= plaintext ^ rk[0]; round <= 1; busy <= 1; go to ROUND.
  - start while key_ready=0 is ignored with no side effects.
  - start and key_ready rising in the same cycle: the block is accepted.
- ROUND, round r < nr: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk[r]; round <= r+1.
- ROUND, round r == nr (final round, no MixColumns):
  - ciphertext <= ShiftRows(SubBytes(state)) ^ rk[nr].
  - done <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency: the start-sampling edge is edge 0. done and the new ciphertext are registered on edge nr: 10, 12 or 14 edges for AES-128, 192 or 256.
- Back-to-back: start may be asserted in the cycle done is high. It is accepted on the next edge, giving a throughput of one block per nr+1 cycles.
- start while busy is ignored; plaintext is not re-sampled.
- key_ready deasserting while busy aborts the block: next edge goes to IDLE, busy=0, no done, ciphertext unchanged.
- ciphertext holds its last value until the next successful completion.
- kall must be stable while busy; the engine reads rk[r] combinationally each round.
- SubBytes uses 16 parallel S-box lookups. MixColumns uses xtime (shift left, XOR 0x1b on carry) over GF(2^8).
- round counter is 4 bits; values above nr are unreachable.

Optional Feature:
- Macro AES_START_ERR_EN.
- Defined: adds output port start_err (1 bit, reset 0). It pulses high for one cycle on any edge where start=1 is rejected, i.e. key_ready=0 while in IDLE, or the engine is busy. Accepted starts never pulse it.
- Undefined: port absent; rejected starts are silent. Datapath and timing are identical either way.

Test Plan:
- AES-128 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, key_ready=1, plaintext 00112233445566778899aabbccddeeff, start pulse -> done on edge 10, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, busy low after.
- AES-128 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32; then an immediate second start with the C.1 plaintext -> 69c4e0d86a7b0430d8cdb78070b4c55a 11 cycles after the first done.
- AES-256 (size=256): key 000102...1e1f, plaintext 00112233445566778899aabbccddeeff -> done on edge 14, ciphertext 8ea2b7ca516745bfeafc49904b496089.
- start with key_ready=0 -> no busy, no done, ciphertext stays 0; with AES_START_ERR_EN, start_err pulses once. Also pulse start twice during a busy block -> only one done, with the correct ciphertext.
- Reset low at edge 5 of a block -> busy=0, done=0, ciphertext=0 immediately (asynchronous); after release, a fresh start gives the correct result.
- key_ready dropped at edge 4 -> engine in IDLE at the next edge, no done, previous ciphertext retained.

Source files
------------

// File: rtl/aes_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_engine
// Brief    : Iterative AES encryption datapath, one round per clock, fed by a
//            precomputed round-key bus. Optional macro: AES_START_ERR_EN
//            (adds start_err pulse for rejected start requests).
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_engine #(
  parameter int size = 128
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [128*(size/32+7)-1:0]  kall,
  input  logic                        key_ready,
  input  logic                        start,
  input  logic [127:0]                plaintext,
  output logic                        busy,
  output logic [127:0]                ciphertext,
  output logic                        done
`ifdef AES_START_ERR_EN
  ,
  output logic                        start_err
`endif
);

  localparam int c_NR = size/32 + 6;

  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ROUND = 1'b1
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    int idx;
    idx  = 255 - int'(x);
    sbox = c_SBOX[idx*8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  state_t       r_fsm, w_fsm_nxt;
  logic [127:0] r_state, w_state_nxt;
  logic [3:0]   r_round, w_round_nxt;
  logic         r_busy, w_busy_nxt;
  logic         r_done, w_done_nxt;
  logic [127:0] r_ct, w_ct_nxt;
`ifdef AES_START_ERR_EN
  logic         r_start_err, w_start_err_nxt;
`endif

  logic [127:0] w_rk_arr [0:15];
  logic [127:0] w_rk;
  logic [7:0]   w_sb [0:15];
  logic [7:0]   w_sr [0:15];
  logic [7:0]   w_mc [0:15];
  logic [127:0] w_sr_flat, w_mc_flat;

  // Round-key table padded to the counter range; unused slots are never selected.
  for (genvar i = 0; i < 16; i++) begin : g_rk
    if (i <= c_NR) begin : g_used
      assign w_rk_arr[i] = kall[128*(c_NR+1)-1-128*i -: 128];
    end else begin : g_unused
      assign w_rk_arr[i] = '0;
    end
  end
  assign w_rk = w_rk_arr[r_round];

  for (genvar b = 0; b < 16; b++) begin : g_sub
    assign w_sb[b] = sbox(r_state[127-8*b -: 8]);
  end

  // Byte b sits at row b%4, column b/4; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
    end
    assign w_mc[4*c+0] = xtime(w_sr[4*c+0]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1]
                         ^ w_sr[4*c+2] ^ w_sr[4*c+3];
    assign w_mc[4*c+1] = w_sr[4*c+0] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2])
                         ^ w_sr[4*c+2] ^ w_sr[4*c+3];
    assign w_mc[4*c+2] = w_sr[4*c+0] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2])
                         ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
    assign w_mc[4*c+3] = xtime(w_sr[4*c+0]) ^ w_sr[4*c+0] ^ w_sr[4*c+1]
                         ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
  end

  for (genvar b = 0; b < 16; b++) begin : g_pack
    assign w_sr_flat[127-8*b -: 8] = w_sr[b];
    assign w_mc_flat[127-8*b -: 8] = w_mc[b];
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_ct_nxt    = r_ct;
`ifdef AES_START_ERR_EN
    w_start_err_nxt = 1'b0;
`endif
    case (r_fsm)
      S_IDLE: begin
        if (start && key_ready) begin
          w_state_nxt = plaintext ^ w_rk_arr[0];
          w_round_nxt = 4'd1;
          w_busy_nxt  = 1'b1;
          w_fsm_nxt   = S_ROUND;
        end
`ifdef AES_START_ERR_EN
        else if (start) begin
          w_start_err_nxt = 1'b1;
        end
`endif
      end
      S_ROUND: begin
`ifdef AES_START_ERR_EN
        w_start_err_nxt = start;
`endif
        if (!key_ready) begin
          w_fsm_nxt   = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_round_nxt = 4'd0;
        end else if (r_round == 4'(c_NR)) begin
          w_ct_nxt    = w_sr_flat ^ w_rk;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_round_nxt = 4'd0;
          w_fsm_nxt   = S_IDLE;
        end else begin
          w_state_nxt = w_mc_flat ^ w_rk;
          w_round_nxt = r_round + 4'd1;
        end
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_round <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ct    <= '0;
`ifdef AES_START_ERR_EN
      r_start_err <= 1'b0;
`endif
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ct    <= w_ct_nxt;
`ifdef AES_START_ERR_EN
      r_start_err <= w_start_err_nxt;
`endif
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign ciphertext = r_ct;
`ifdef AES_START_ERR_EN
  assign start_err  = r_start_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_round_engine.sv
`default_nettype none
// Scoreboard bench for aes_round_engine: AES-128 and AES-256 instances driven
// with FIPS-197 vectors; round keys are expanded locally from the cipher keys.
module tb_aes_round_engine;

  localparam logic [2047:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY_256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    logic [127:0] ct;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [1407:0] kall1;
  logic [1919:0] kall2;
  logic key_ready1, key_ready2, start1, start2;
  logic [127:0] pt1, pt2, ct1, ct2;
  logic busy1, busy2, done1, done2;
`ifdef AES_START_ERR_EN
  logic start_err1, start_err2;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_engine #(.size(128)) u_dut128 (
    .clk(clk), .reset(rst_n), .kall(kall1), .key_ready(key_ready1),
    .start(start1), .plaintext(pt1), .busy(busy1), .ciphertext(ct1),
    .done(done1)
`ifdef AES_START_ERR_EN
    , .start_err(start_err1)
`endif
  );

  aes_round_engine #(.size(256)) u_dut256 (
    .clk(clk), .reset(rst_n), .kall(kall2), .key_ready(key_ready2),
    .start(start2), .plaintext(pt2), .busy(busy2), .ciphertext(ct2),
    .done(done2)
`ifdef AES_START_ERR_EN
    , .start_err(start_err2)
`endif
  );

  function automatic logic [7:0] sb(input logic [7:0] x);
    int idx;
    idx = 255 - int'(x);
    sb  = SB[idx*8 +: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    subw = {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  // FIPS-197 key expansion; word i lands at [1919-32*i], round key 0 in MSBs.
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]   w [0:59];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] res;
    int nr;
    nr  = nk + 6;
    rc  = 8'h01;
    res = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 4*(nr+1); i++) res[1919-32*i -: 32] = w[i];
    expand = res;
  endfunction

  task automatic set_key128(input logic [127:0] key);
    logic [1919:0] full;
    full  = expand({key, 128'h0}, 4);
    kall1 = full[1919 -: 1408];
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_q(input int which, input int bound);
    int k = 0;
    while (((which == 1) ? q1.size() : q2.size()) != 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (((which == 1) ? q1.size() : q2.size()) != 0) begin
      n_fail++;
      $display("FAIL timeout_done%0d: got no done within %0d cycles, required done", which, bound);
      if (which == 1) q1.delete(); else q2.delete();
    end
  endtask

  task automatic issue1(input logic [127:0] pt, input logic [127:0] exp_ct, input bit expect_done);
    exp_t e;
    pt1    = pt;
    start1 = 1'b1;
    if (expect_done) begin
      e.ct  = exp_ct;
      e.cyc = cyc + 1 + 10;
      q1.push_back(e);
    end
    @(negedge clk);
    start1 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && done1) begin
      exp_t e;
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done128: got done with ct %h, required no done", ct1);
      end else begin
        e = q1.pop_front();
        chk("ct128", ct1, e.ct);
        chk("latency128", 128'(cyc), 128'(e.cyc));
        chk("busy_at_done128", {127'h0, busy1}, 128'h0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done2) begin
      exp_t e;
      n_tests++;
      if (q2.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done256: got done with ct %h, required no done", ct2);
      end else begin
        e = q2.pop_front();
        chk("ct256", ct2, e.ct);
        chk("latency256", 128'(cyc), 128'(e.cyc));
        chk("busy_at_done256", {127'h0, busy2}, 128'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    exp_t e;
    rst_n = 1'b0; key_ready1 = 1'b0; key_ready2 = 1'b0;
    start1 = 1'b0; start2 = 1'b0; pt1 = '0; pt2 = '0;
    kall1 = '0; kall2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy128", {127'h0, busy1}, 128'h0);
    chk("reset_done128", {127'h0, done1}, 128'h0);
    chk("reset_ct128", ct1, 128'h0);
    chk("reset_busy256", {127'h0, busy2}, 128'h0);
    chk("reset_ct256", ct2, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // start with no keys is dropped
    set_key128(KEY_C1);
    issue1(PT_C1, '0, 1'b0);
    chk("nokey_busy", {127'h0, busy1}, 128'h0);
`ifdef AES_START_ERR_EN
    chk("nokey_start_err", {127'h0, start_err1}, 128'h1);
    @(negedge clk);
    chk("nokey_start_err_clear", {127'h0, start_err1}, 128'h0);
`endif
    repeat (12) @(negedge clk);
    chk("nokey_ct", ct1, 128'h0);

    // C.1 with key_ready rising together with start
    key_ready1 = 1'b1;
    issue1(PT_C1, CT_C1, 1'b1);
    chk("c1_busy", {127'h0, busy1}, 128'h1);
    wait_q(1, 20);
    chk("c1_busy_after", {127'h0, busy1}, 128'h0);

    // Appendix B, then back-to-back C.1 started in the done cycle
    set_key128(KEY_B);
    issue1(PT_B, CT_B, 1'b1);
    k = 0;
    while (!done1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b_done_seen", {127'h0, done1}, 128'h1);
    set_key128(KEY_C1);
    pt1 = PT_C1;
    start1 = 1'b1;
    e.ct = CT_C1;
    e.cyc = cyc + 11;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    chk("b2b_busy", {127'h0, busy1}, 128'h1);
    wait_q(1, 20);

    // extra starts while busy are ignored
    issue1(PT_C1, CT_C1, 1'b1);
    repeat (2) @(negedge clk);
    pt1 = PT_B;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("busy_start_busy", {127'h0, busy1}, 128'h1);
`ifdef AES_START_ERR_EN
    chk("busy_start_err", {127'h0, start_err1}, 128'h1);
`endif
    repeat (2) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_q(1, 20);
    repeat (12) @(negedge clk);

    // asynchronous reset mid-block
    issue1(PT_C1, CT_C1, 1'b1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {127'h0, busy1}, 128'h0);
    chk("async_rst_done", {127'h0, done1}, 128'h0);
    chk("async_rst_ct", ct1, 128'h0);
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue1(PT_C1, CT_C1, 1'b1);
    wait_q(1, 20);

    // key_ready dropped at edge 4 aborts
    set_key128(KEY_B);
    issue1(PT_B, '0, 1'b0);
    chk("abort_busy_before", {127'h0, busy1}, 128'h1);
    repeat (3) @(negedge clk);
    key_ready1 = 1'b0;
    @(negedge clk);
    chk("abort_busy", {127'h0, busy1}, 128'h0);
    chk("abort_ct_kept", ct1, CT_C1);
    repeat (15) @(negedge clk);
    chk("abort_ct_later", ct1, CT_C1);
    key_ready1 = 1'b1;

    // AES-256
    kall2 = expand(KEY_256, 8);
    key_ready2 = 1'b1;
    pt2 = PT_C1;
    start2 = 1'b1;
    e.ct = CT_256;
    e.cyc = cyc + 1 + 14;
    q2.push_back(e);
    @(negedge clk);
    start2 = 1'b0;
    chk("aes256_busy", {127'h0, busy2}, 128'h1);
    wait_q(2, 25);
    repeat (3) @(negedge clk);
    chk("aes256_ct_hold", ct2, CT_256);
    chk("ct128_hold", ct1, CT_C1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
